// File: rtl/trisc_mem_pkg.sv
// trisc_mem_pkg: shared state encoding, port owner enum and default widths
// for the memory port arbiter.
package trisc_mem_pkg;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, DONE} state_t;
    typedef enum logic {CPU, LDR} owner_t;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: chooses the winner among the CPU and loader requests; on a tie
// the requester that did not win last time is picked.
module arb_pick
    import trisc_mem_pkg::*;
(
    input  logic   cpu_req,
    input  logic   ldr_req,
    input  owner_t last_owner,
    output owner_t winner
);
    // A last_owner tied to LDR turns the tie rule into fixed CPU priority.
    assign winner = (cpu_req && ldr_req) ? (last_owner == CPU ? LDR : CPU)
                  : (cpu_req ? CPU : LDR);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU and the program
// loader; define ARB_RR_EN for alternating tie-break instead of CPU priority.
module mem_port_arbiter
    import trisc_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_xfer,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t state;
    owner_t owner, winner, last_owner;
    logic any_req, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign any_req   = cpu_req || ldr_req;
    assign sel_we    = winner == CPU ? cpu_we : ldr_we;
    assign sel_addr  = winner == CPU ? cpu_addr : ldr_addr;
    assign sel_wdata = winner == CPU ? cpu_wdata : ldr_wdata;

    arb_pick u_pick (
        .cpu_req   (cpu_req),
        .ldr_req   (ldr_req),
        .last_owner(last_owner),
        .winner    (winner)
    );

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge CLR)
        if (CLR) last_owner <= LDR;
        else if (state == IDLE && any_req) last_owner <= winner;
`else
    assign last_owner = LDR;
`endif

    // Outputs are registered: each one is loaded with its value for the state being entered.
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            state     <= IDLE;
            owner     <= CPU;
            cpu_gnt   <= 1'b0;
            ldr_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            ldr_done  <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_xfer  <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner     <= winner;
                    mem_addr  <= sel_addr;
                    mem_wdata <= sel_wdata;
                    mem_rd    <= !sel_we;
                    mem_we    <= sel_we;
                    cpu_gnt   <= winner == CPU;
                    ldr_gnt   <= winner == LDR;
                    state     <= sel_we ? WR_A : RD_A;
                end
                RD_A: begin
                    mem_xfer <= 1'b1;
                    state    <= RD_B;
                end
                RD_B: begin
                    mem_rd   <= 1'b0;
                    mem_xfer <= 1'b0;
                    if (owner == CPU) cpu_rdata <= mem_rdata;
                    else ldr_rdata <= mem_rdata;
                    cpu_done <= owner == CPU;
                    ldr_done <= owner == LDR;
                    state    <= DONE;
                end
                WR_A: state <= WR_B;
                WR_B: begin
                    mem_we   <= 1'b0;
                    cpu_done <= owner == CPU;
                    ldr_done <= owner == LDR;
                    state    <= DONE;
                end
                DONE: begin
                    cpu_gnt  <= 1'b0;
                    ldr_gnt  <= 1'b0;
                    cpu_done <= 1'b0;
                    ldr_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed transactions against a
// transaction-level model of the arbiter and its attached memory.
module tb_mem_port_arbiter;
`ifdef ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0, CLR = 1'b1;
    logic cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0;
    logic [3:0] cpu_addr = 0, ldr_addr = 0, mem_addr;
    logic [7:0] cpu_wdata = 0, ldr_wdata = 0, mem_wdata, mem_rdata, cpu_rdata, ldr_rdata;
    logic cpu_gnt, cpu_done, ldr_gnt, ldr_done, mem_rd, mem_xfer, mem_we;
    logic [7:0] mem [16];
    logic [7:0] ref_mem [16];
    logic [7:0] rd_m [2];
    bit last_own = 1'b1;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    mem_port_arbiter dut (
        .clk(clk), .CLR(CLR),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
        .mem_xfer(mem_xfer), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] bus();
        return {cpu_gnt, ldr_gnt, mem_rd, mem_xfer, mem_we, cpu_done, ldr_done};
    endfunction

    // Winner rule: lone requester wins; tie goes to CPU, or to the non-last owner when RR.
    function automatic bit pick(bit c, bit l);
        if (c && l) return RR && !last_own;
        return !c;
    endfunction

    task automatic run_txn(input bit cr, input bit lr, input bit cwe, input bit lwe,
                           input logic [3:0] ca, input logic [3:0] la,
                           input logic [7:0] cd, input logic [7:0] ld, input bit scr);
        bit win, we;
        logic [3:0] a;
        logic [7:0] d;
        win = pick(cr, lr);
        we = win ? lwe : cwe;
        a = win ? la : ca;
        d = win ? ld : cd;
        cpu_req = cr; ldr_req = lr; cpu_we = cwe; ldr_we = lwe;
        cpu_addr = ca; ldr_addr = la; cpu_wdata = cd; ldr_wdata = ld;
        tick();
        check("a_bus", bus(), {~win, win, !we, 1'b0, we, 2'b00});
        check("a_addr", mem_addr, a);
        cpu_req = 0; ldr_req = 0;
        if (scr) begin
            cpu_addr++; ldr_addr++; cpu_we = ~cpu_we; ldr_we = ~ldr_we;
            cpu_wdata = ~cpu_wdata; ldr_wdata = ~ldr_wdata;
        end
        tick();
        check("b_bus", bus(), {~win, win, !we, !we, we, 2'b00});
        check("b_addr", mem_addr, a);
        if (we) check("b_wdata", mem_wdata, d);
        tick();
        if (we) ref_mem[a] = d;
        else rd_m[win] = ref_mem[a];
        last_own = win;
        check("c_bus", bus(), {~win, win, 3'b000, ~win, win});
        check("c_addr", mem_addr, a);
        check("cpu_rdata", cpu_rdata, rd_m[0]);
        check("ldr_rdata", ldr_rdata, rd_m[1]);
        tick();
        check("idle_bus", bus(), 0);
        check("mem_word", mem[a], ref_mem[a]);
    endtask

    initial begin
        int n;
        bit prev, cr, lr;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        rd_m[0] = 0; rd_m[1] = 0;
        #3;
        check("rst_bus", bus(), 0);
        check("rst_addr", {mem_addr, mem_wdata}, 0);
        check("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
        tick(); tick();
        CLR = 0;
        tick();
        check("rst_idle", bus(), 0);

        mem[3] = 8'hA5; ref_mem[3] = 8'hA5;
        run_txn(1, 0, 0, 0, 4'h3, 4'h0, 8'h00, 8'h00, 0);
        check("cpu_rd_a5", cpu_rdata, 8'hA5);
        run_txn(0, 1, 0, 1, 4'h0, 4'hF, 8'h00, 8'h3C, 0);
        run_txn(1, 0, 0, 0, 4'hF, 4'h0, 8'h00, 8'h00, 0);
        check("readback_3c", cpu_rdata, 8'h3C);
        run_txn(1, 0, 1, 0, 4'h1, 4'h0, 8'h5A, 8'h00, 1);

        cpu_req = 1; ldr_req = 1; cpu_we = 0; ldr_we = 0; cpu_addr = 5; ldr_addr = 5;
        n = 0; prev = 0;
        for (int i = 0; i < 24 && n < 4; i++) begin
            tick();
            if ((cpu_gnt || ldr_gnt) && !prev) begin
                bit w;
                w = pick(1, 1);
                check($sformatf("tie%0d", n), {cpu_gnt, ldr_gnt}, {~w, w});
                last_own = w;
                rd_m[w] = ref_mem[5];
                n++;
            end
            prev = cpu_gnt || ldr_gnt;
        end
        check("tie_count", n, 4);
        cpu_req = 0; ldr_req = 0;
        tick(); tick(); tick();
        check("tie_idle", bus(), 0);
        check("tie_rdata", {cpu_rdata, ldr_rdata}, {rd_m[0], rd_m[1]});

        cpu_req = 1; cpu_we = 0; cpu_addr = 4'h3;
        tick();
        cpu_req = 0;
        tick();
        CLR = 1;
        #1;
        check("clr_bus", bus(), 0);
        check("clr_addr", {mem_addr, mem_wdata}, 0);
        check("clr_rdata", {cpu_rdata, ldr_rdata}, 0);
        rd_m[0] = 0; rd_m[1] = 0; last_own = 1'b1;
        tick();
        CLR = 0;
        tick(); tick();
        check("clr_after", bus(), 0);
        check("clr_rdata2", {cpu_rdata, ldr_rdata}, 0);

        for (int i = 0; i < 40; i++) begin
            cr = 1'($urandom); lr = 1'($urandom);
            if (!cr && !lr) cr = 1;
            run_txn(cr, lr, 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                    8'($urandom), 8'($urandom), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
